// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants and state encoding for the SRAM arbiter client
package sram_pkg;

    // Default arbiter geometry: word address width and the number of cycles
    // between the ack match and the arbiter's read data register being valid.
    localparam int SRAM_ADDR_W       = 20;
    localparam int SRAM_DATA_LATENCY = 4;

    // Encoding of the access direction on sram_read / cmd_read.
    localparam logic DIR_READ  = 1'b1;
    localparam logic DIR_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_WR    = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DATA = 3'd4,
        ST_DELIVER   = 3'd5,
        ST_NEXT      = 3'd6
    } burst_state_t;

endpackage

// File: rtl/sram_burst_client.sv
// rtl/sram_burst_client.sv - burst master for one toggle req/ack SRAM arbiter client port
//
// Ports:
//   clk200, reset                     clock and synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_*        burst command: direction, start address, count-1, lanes
//   wr_valid/wr_ready/wr_data         write word stream into the client
//   rd_valid/rd_ready/rd_data         read word stream out of the client
//   busy                              high whenever a burst is in progress
//   sram_req/sram_ack                 toggle handshake; request outstanding while they differ
//   sram_read/address/lb/ub/wdata     registered access fields, stable while outstanding
//   sram_rdata                        arbiter read data register
module sram_burst_client
    import sram_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int LEN_W       = 8,
    parameter int ACK_TO_DATA = SRAM_DATA_LATENCY
) (
    input  logic              clk200,
    input  logic              reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_read,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [LEN_W-1:0]  cmd_last,
    input  logic              cmd_lb,
    input  logic              cmd_ub,

    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [15:0]       wr_data,

    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [15:0]       rd_data,

    output logic              busy,

    output logic              sram_req,
    input  logic              sram_ack,
    output logic              sram_read,
    output logic [ADDR_W-1:0] sram_address,
    output logic              sram_lb,
    output logic              sram_ub,
    output logic [15:0]       sram_wdata,
    input  logic [15:0]       sram_rdata
);

    localparam int               CNT_W    = (ACK_TO_DATA > 1) ? $clog2(ACK_TO_DATA) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACK_TO_DATA - 1);

    burst_state_t     state;
    burst_state_t     state_next;
    logic [LEN_W-1:0] remaining;
    logic [CNT_W-1:0] lat_cnt;
    logic             ack_match;

    assign ack_match = (sram_ack == sram_req);

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_next = (cmd_read == DIR_READ) ? ST_ISSUE : ST_GET_WR;
                end
            end
            ST_GET_WR: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (ack_match) begin
                    state_next = (sram_read == DIR_READ) ? ST_WAIT_DATA : ST_NEXT;
                end
            end
            ST_WAIT_DATA: begin
                if (lat_cnt == '0) begin
                    state_next = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                // Holding here until the consumer takes the word is what keeps
                // the next read from being issued early.
                if (rd_ready) begin
                    state_next = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (remaining == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = (sram_read == DIR_READ) ? ST_ISSUE : ST_GET_WR;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk200) begin
        if (reset) begin
            state        <= ST_IDLE;
            // Match whatever the arbiter currently shows so nothing looks
            // outstanding; an in-flight access is simply abandoned.
            sram_req     <= sram_ack;
            sram_read    <= DIR_READ;
            sram_address <= '0;
            sram_lb      <= 1'b0;
            sram_ub      <= 1'b0;
            sram_wdata   <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            remaining    <= '0;
            lat_cnt      <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        sram_address <= cmd_address;
                        remaining    <= cmd_last;
                        sram_read    <= cmd_read;
                        sram_lb      <= cmd_lb;
                        sram_ub      <= cmd_ub;
                    end
                end
                ST_GET_WR: begin
                    if (wr_valid) begin
                        sram_wdata <= wr_data;
                    end
                end
                ST_ISSUE: begin
                    sram_req <= ~sram_req;
                end
                ST_WAIT_ACK: begin
                    lat_cnt <= CNT_LOAD;
                end
                ST_WAIT_DATA: begin
                    if (lat_cnt == '0) begin
                        rd_data  <= sram_rdata;
                        rd_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end
                ST_DELIVER: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                    end
                end
                ST_NEXT: begin
                    // Address wraps naturally at the top of the word space.
                    if (remaining != '0) begin
                        sram_address <= sram_address + ADDR_W'(1);
                        remaining    <= remaining - LEN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_burst_client.sv
// tb/tb_sram_burst_client.sv - randomized self-checking bench for sram_burst_client
module tb_sram_burst_client;

    localparam int ADDR_W = 20;
    localparam int LEN_W  = 8;
    localparam int A2D    = 4;

    logic              clk200 = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_read;
    logic [ADDR_W-1:0] cmd_address;
    logic [LEN_W-1:0]  cmd_last;
    logic              cmd_lb;
    logic              cmd_ub;
    logic              wr_valid;
    logic              wr_ready;
    logic [15:0]       wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [15:0]       rd_data;
    logic              busy;
    logic              sram_req;
    logic              sram_ack = 1'b0;
    logic              sram_read;
    logic [ADDR_W-1:0] sram_address;
    logic              sram_lb;
    logic              sram_ub;
    logic [15:0]       sram_wdata;
    logic [15:0]       sram_rdata = 16'h0;

    always #5 clk200 = ~clk200;

    sram_burst_client #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ACK_TO_DATA(A2D)) dut (
        .clk200(clk200), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_address(cmd_address), .cmd_last(cmd_last), .cmd_lb(cmd_lb), .cmd_ub(cmd_ub),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy),
        .sram_req(sram_req), .sram_ack(sram_ack), .sram_read(sram_read),
        .sram_address(sram_address), .sram_lb(sram_lb), .sram_ub(sram_ub),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    typedef struct {
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic              lb;
        logic              ub;
        logic [15:0]       wdata;
    } acc_t;

    int tests_run    = 0;
    int tests_failed = 0;

    acc_t        exp_acc[$];
    acc_t        acc_log[$];
    logic [15:0] wr_q[$];
    logic [15:0] cmd_words[$];
    logic [15:0] exp_rd[$];
    logic [15:0] got_rd[$];
    logic [15:0] dir_words[$];

    int  wr_pushed      = 0;
    int  wr_popped      = 0;
    bit  wr_hs          = 0;
    bit  in_reset       = 1;
    bit  arb_hold       = 0;
    int  arb_delay_fixed = -1;
    int  wr_gap         = 0;
    int  rd_ready_mode  = 1;
    bit  noise          = 0;

    bit          pending = 0;
    int          dly     = 0;
    int          data_cd = 0;
    logic [15:0] data_word;
    acc_t        cap;
    acc_t        arb_a;
    acc_t        arb_e;
    bit          prev_hold = 0;
    logic [15:0] prev_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Arbiter model: one access at a time, ack after a chosen delay, and the
    // read word present on sram_rdata only during the one cycle in which it
    // must be sampled (random garbage otherwise).
    always @(posedge clk200) begin
        #1;
        sram_rdata = 16'($urandom);
        if (data_cd == 1) sram_rdata = data_word;
        if (data_cd > 0) data_cd--;
        if (in_reset) begin
            pending = 0;
            data_cd = 0;
        end else if (pending) begin
            chk("stable_read", sram_read, cap.rd);
            chk("stable_addr", sram_address, cap.addr);
            chk("stable_lb", sram_lb, cap.lb);
            chk("stable_ub", sram_ub, cap.ub);
            chk("stable_wdata", sram_wdata, cap.wdata);
            dly--;
            if (dly <= 0) begin
                sram_ack = sram_req;
                pending  = 0;
                if (cap.rd) data_cd = A2D;
            end
        end else if (!arb_hold && sram_req != sram_ack) begin
            arb_a.rd    = sram_read;
            arb_a.addr  = sram_address;
            arb_a.lb    = sram_lb;
            arb_a.ub    = sram_ub;
            arb_a.wdata = sram_wdata;
            acc_log.push_back(arb_a);
            if (exp_acc.size() == 0) begin
                chk("extra_toggle", 1, 0);
            end else begin
                arb_e = exp_acc.pop_front();
                chk("acc_read", arb_a.rd, arb_e.rd);
                chk("acc_addr", arb_a.addr, arb_e.addr);
                chk("acc_lb", arb_a.lb, arb_e.lb);
                chk("acc_ub", arb_a.ub, arb_e.ub);
                if (!arb_e.rd) chk("acc_wdata", arb_a.wdata, arb_e.wdata);
            end
            if (arb_a.rd) begin
                chk("read_before_accept", exp_rd.size() + int'(rd_valid), 0);
                data_word = (dir_words.size() > 0) ? dir_words.pop_front() : 16'($urandom);
                exp_rd.push_back(data_word);
            end
            cap     = arb_a;
            pending = 1;
            dly     = (arb_delay_fixed >= 0) ? arb_delay_fixed : $urandom_range(0, 6);
            if (dly == 0) begin
                sram_ack = sram_req;
                pending  = 0;
                if (cap.rd) data_cd = A2D;
            end
        end
    end

    // Stream drivers.
    always @(posedge clk200) begin
        #1;
        if (wr_hs) begin
            void'(wr_q.pop_front());
            wr_popped++;
        end
        if (wr_q.size() > 0 && $urandom_range(99) >= wr_gap) begin
            wr_valid = 1'b1;
            wr_data  = wr_q[0];
        end else begin
            wr_valid = 1'b0;
            wr_data  = 16'($urandom);
        end
        rd_ready = (rd_ready_mode == 2) ? 1'($urandom_range(1)) : (rd_ready_mode == 1);
    end

    // Output compare process.
    always @(negedge clk200) begin
        wr_hs = wr_valid && wr_ready;
        if (in_reset) begin
            prev_hold = 0;
        end else begin
            chk("busy_vs_cmd_ready", busy, !cmd_ready);
            if (wr_ready) begin
                chk("wr_ready_need", (wr_pushed - wr_popped) > 0, 1);
                chk("wr_ready_no_outstanding", sram_req == sram_ack, 1);
            end
            if (prev_hold) begin
                chk("rd_valid_hold", rd_valid, 1);
                chk("rd_data_hold", rd_data, prev_data);
            end
            if (rd_valid) chk("rd_valid_expected", exp_rd.size() > 0, 1);
            if (rd_valid && rd_ready && exp_rd.size() > 0) begin
                chk("rd_data", rd_data, exp_rd.pop_front());
                got_rd.push_back(rd_data);
            end
            prev_hold = rd_valid && !rd_ready;
            prev_data = rd_data;
        end
    end

    task automatic send_cmd(input logic rd, input logic [ADDR_W-1:0] addr, input int last,
                            input logic lb, input logic ub);
        int   n;
        acc_t a;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge clk200); #1;
            n++;
        end
        chk("cmd_ready_timeout", n < 200, 1);
        for (int i = 0; i <= last; i++) begin
            a.rd    = rd;
            a.addr  = ADDR_W'(addr + ADDR_W'(i));
            a.lb    = lb;
            a.ub    = ub;
            a.wdata = 16'h0;
            if (!rd) begin
                a.wdata = (cmd_words.size() > 0) ? cmd_words.pop_front() : 16'($urandom);
                wr_q.push_back(a.wdata);
                wr_pushed++;
            end
            exp_acc.push_back(a);
        end
        cmd_valid   = 1'b1;
        cmd_read    = rd;
        cmd_address = addr;
        cmd_last    = LEN_W'(last);
        cmd_lb      = lb;
        cmd_ub      = ub;
        @(posedge clk200); #1;
        cmd_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk200); #1;
            n++;
            cmd_valid = noise && busy && $urandom_range(1) == 1;
            if (noise) begin
                cmd_read    = 1'($urandom);
                cmd_address = ADDR_W'($urandom);
                cmd_last    = LEN_W'($urandom);
            end
        end while (!(!busy && exp_acc.size() == 0 && exp_rd.size() == 0 &&
                     wr_pushed == wr_popped) && n < budget);
        cmd_valid = 1'b0;
        chk("burst_done_timeout", n < budget, 1);
    endtask

    initial begin
        int          n;
        logic [15:0] d;
        logic [ADDR_W-1:0] ra;
        int          rl;
        reset = 1'b1; cmd_valid = 0; cmd_read = 0; cmd_address = 0; cmd_last = 0;
        cmd_lb = 0; cmd_ub = 0; wr_valid = 0; wr_data = 0; rd_ready = 1;
        repeat (3) @(posedge clk200);
        #1 reset = 1'b0; in_reset = 0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_req", sram_req, 0);
        chk("rst_sram_read", sram_read, 1);
        chk("rst_addr", sram_address, 0);
        chk("rst_lanes", {sram_lb, sram_ub}, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_rd_data", rd_data, 0);

        // Write burst, four words.
        arb_delay_fixed = 3; acc_log.delete();
        cmd_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        send_cmd(1'b0, 20'h00100, 3, 1'b1, 1'b1);
        wait_done(400);
        chk("t1_toggles", acc_log.size(), 4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++) begin
            chk("t1_addr", acc_log[i].addr, 20'h00100 + 20'(i));
            chk("t1_wdata", acc_log[i].wdata, 16'h1111 * 16'(i + 1));
        end

        // Read burst with same-cycle ack.
        arb_delay_fixed = 0; acc_log.delete(); got_rd.delete();
        dir_words = '{16'hBEEF, 16'hCAFE};
        send_cmd(1'b1, 20'h00200, 1, 1'b1, 1'b1);
        wait_done(400);
        chk("t2_words", got_rd.size(), 2);
        if (got_rd.size() == 2) begin
            chk("t2_word0", got_rd[0], 16'hBEEF);
            chk("t2_word1", got_rd[1], 16'hCAFE);
        end

        // Read backpressure.
        arb_delay_fixed = -1; acc_log.delete(); rd_ready_mode = 0;
        send_cmd(1'b1, 20'h00300, 1, 1'b0, 1'b1);
        n = 0;
        while (!rd_valid && n < 100) begin @(posedge clk200); #1; n++; end
        chk("t3_rd_valid_timeout", n < 100, 1);
        d = rd_data;
        repeat (10) begin
            @(posedge clk200); #1;
            chk("t3_hold_valid", rd_valid, 1);
            chk("t3_hold_data", rd_data, d);
        end
        chk("t3_no_second_toggle", acc_log.size(), 1);
        rd_ready_mode = 1;
        wait_done(400);
        chk("t3_toggles", acc_log.size(), 2);

        // Address wrap.
        acc_log.delete();
        send_cmd(1'b0, 20'hFFFFF, 1, 1'b1, 1'b0);
        wait_done(400);
        chk("t4_toggles", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            chk("t4_addr0", acc_log[0].addr, 20'hFFFFF);
            chk("t4_addr1", acc_log[1].addr, 20'h00000);
        end

        // Slow arbiter with write stream gaps.
        arb_delay_fixed = 20; wr_gap = 60; acc_log.delete();
        send_cmd(1'b0, 20'h12345, 3, 1'b0, 1'b0);
        wait_done(1000);
        chk("t5_toggles", acc_log.size(), 4);

        // Randomized bursts, with ignored command noise while busy.
        arb_delay_fixed = -1; wr_gap = 30; rd_ready_mode = 2; noise = 1;
        for (int k = 0; k < 25; k++) begin
            ra = ($urandom_range(3) == 0) ? 20'hFFFFF - 20'($urandom_range(3)) : 20'($urandom);
            rl = (k == 7) ? 255 : $urandom_range(0, 7);
            send_cmd(1'($urandom), ra, rl, 1'($urandom), 1'($urandom));
            wait_done(300 + (rl + 1) * 80);
        end
        noise = 0; rd_ready_mode = 1; wr_gap = 0;

        // Reset while a read is outstanding with ack=1, req=0.
        if (sram_ack == 1'b0) begin
            send_cmd(1'b1, 20'h00050, 0, 1'b1, 1'b1);
            wait_done(400);
        end
        arb_hold = 1;
        send_cmd(1'b1, 20'h00400, 2, 1'b1, 1'b0);
        n = 0;
        while (sram_req == sram_ack && n < 20) begin @(posedge clk200); #1; n++; end
        chk("t6_outstanding", {sram_req, sram_ack}, 2'b01);
        repeat (3) @(posedge clk200);
        #1 reset = 1'b1; in_reset = 1;
        exp_acc.delete(); exp_rd.delete();
        repeat (2) @(posedge clk200);
        #1 reset = 1'b0; in_reset = 0; arb_hold = 0; acc_log.delete();
        chk("t6_req", sram_req, 1);
        chk("t6_ack", sram_ack, 1);
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_cmd_ready", cmd_ready, 1);
        chk("t6_busy", busy, 0);
        repeat (20) @(posedge clk200);
        #1 chk("t6_no_toggle", acc_log.size(), 0);

        // Recovery after reset.
        send_cmd(1'b0, 20'h00777, 2, 1'b1, 1'b1);
        wait_done(400);
        chk("t7_toggles", acc_log.size(), 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
